// File: rtl/reg_file_param.sv
// Parametrised register file with clear sweep and busy/drop handshake.
// Optional write-to-read bypass when REG_FILE_BYPASS_EN is defined.
module reg_file_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      state   <= IDLE;
      ptr     <= '0;
      busy    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_en)
            regs[wr_addr] <= wr_data;
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          regs[ptr] <= '0;
          ptr       <= ptr + 1'b1;
          wr_drop   <= wr_en;
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // busy mirrors CLEAR, so it gates both read ports
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (!busy) begin
      rd_data1 = regs[rd_addr1];
      rd_data2 = regs[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr1))
        rd_data1 = wr_data;
      if (wr_en && (wr_addr == rd_addr2))
        rd_data2 = wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param (8x4 configuration).
// Covers reset, dual reads, bypass, clear sweep, drop and mid-sweep reset.
module tb_reg_file_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr1;
  logic [1:0] rd_addr2;
  logic [7:0] rd_data1;
  logic [7:0] rd_data2;
  logic       clr_req;
  logic       busy;
  logic       wr_drop;

  int total = 0;
  int bad   = 0;

  reg_file_param #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [1:0] a,
                        input logic [7:0] exp);
    rd_addr1 = a;
    rd_addr2 = a;
    #1;
    chk({tag, "_p1"}, 32'(rd_data1), 32'(exp));
    chk({tag, "_p2"}, 32'(rd_data2), 32'(exp));
  endtask

  logic [7:0] ld [4];

  initial begin
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    clr_req  = 1'b0;
    ld[0] = 8'h11;
    ld[1] = 8'h22;
    ld[2] = 8'h33;
    ld[3] = 8'h44;
    step();
    step();
    rst_n = 1'b1;
    step();

    // dirty some registers, then async reset between edges
    wr(2'd0, 8'h99);
    wr(2'd3, 8'h66);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(wr_drop), 32'd0);
    for (int i = 0; i < 4; i++)
      rd_chk("rst_reg", 2'(i), 8'h00);
    rst_n = 1'b1;
    step();

    // dual-port read
    wr(2'd1, 8'hA5);
    wr(2'd2, 8'h3C);
    rd_addr1 = 2'd1;
    rd_addr2 = 2'd2;
    #1;
    chk("rd_p1_r1", 32'(rd_data1), 32'hA5);
    chk("rd_p2_r2", 32'(rd_data2), 32'h3C);
    rd_chk("rd_same", 2'd1, 8'hA5);

    // bypass / same-cycle write visibility
    wr_en    = 1'b1;
    wr_addr  = 2'd3;
    wr_data  = 8'h7E;
    rd_addr1 = 2'd3;
    rd_addr2 = 2'd1;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp_same", 32'(rd_data1), 32'h7E);
`else
    chk("byp_same", 32'(rd_data1), 32'h00);
`endif
    chk("byp_other", 32'(rd_data2), 32'hA5);
    step();
    wr_en = 1'b0;
    #1;
    chk("byp_after", 32'(rd_data1), 32'h7E);

    // clear sweep with mid-sweep clr_req and dropped write
    for (int i = 0; i < 4; i++)
      wr(2'(i), ld[i]);
    rd_chk("pre_clr", 2'd3, 8'h44);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rd_addr1 = 2'd3;
      rd_addr2 = 2'(c);
      #1;
      chk("sw_busy", 32'(busy), 32'd1);
      chk("sw_rd1", 32'(rd_data1), 32'h00);
      chk("sw_rd2", 32'(rd_data2), 32'h00);
      if (c == 1)
        clr_req = 1'b1;
      if (c == 3) begin
        chk("sw_nodrop", 32'(wr_drop), 32'd0);
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = 8'hFF;
      end
      step();
      clr_req = 1'b0;
      wr_en   = 1'b0;
    end
    chk("sw_done", 32'(busy), 32'd0);
    chk("drop_hi", 32'(wr_drop), 32'd1);
    step();
    chk("drop_lo", 32'(wr_drop), 32'd0);
    chk("sw_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++)
      rd_chk("clr_reg", 2'(i), 8'h00);

    // reset in the middle of a sweep
    wr(2'd1, 8'h77);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    wr(2'd0, 8'h5A);
    chk("post_busy", 32'(busy), 32'd0);
    rd_chk("post_r0", 2'd0, 8'h5A);
    rd_chk("post_r1", 2'd1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the CPU's fixed 4×8 register file: `2**ADDR_W` registers of `DATA_W` bits, one write port and two combinational read ports. It adds a sequenced clear sweep with a busy/drop handshake, and optional write-to-read bypass. It sits between the instruction decoder (addresses), the FSM (write enable, clear request) and the ALU (write data, operand reads).

## Interface
- `DATA_W`, default 8, register width in bits.
- `ADDR_W`, default 2, address width; `DEPTH = 2**ADDR_W` registers.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request from the FSM.
- `wr_addr`  in  ADDR_W  destination register from the decoder.
- `wr_data`  in  DATA_W  write data from the ALU or another source.
- `rd_addr1`  in  ADDR_W  operand 1 register address.
- `rd_addr2`  in  ADDR_W  operand 2 register address.
- `rd_data1`  out  DATA_W  operand 1 data (combinational).
- `rd_data2`  out  DATA_W  operand 2 data (combinational).
- `clr_req`  in  1  request to start a clear sweep.
- `busy`  out  1  high while the clear sweep runs.
- `wr_drop`  out  1  one-cycle pulse flagging a write rejected during the sweep.

## Operation
- Storage: `DEPTH` × `DATA_W` flops.
- Reset (`rst_n`=0, asynchronous):
  - all registers, `busy`, `wr_drop` and the sweep pointer go to 0;
  - FSM goes to IDLE;
  - applies mid-sweep as well, aborting the sweep immediately.
- Write in IDLE: on a rising edge with `wr_en`=1, `reg[wr_addr] <= wr_data`.
- Reads in IDLE: `rd_dataN = reg[rd_addrN]`, purely combinational. Both ports may address the same register.
- Reads in CLEAR: `rd_data1` and `rd_data2` are forced to 0.
- FSM states are IDLE and CLEAR.
- IDLE→CLEAR:
  - taken on an edge with `clr_req`=1;
  - pointer loads 0 and `busy` rises after that edge;
  - a `wr_en` on the same edge is still accepted; the sweep later overwrites it with 0.
- CLEAR, each edge: `reg[ptr] <= 0` and `ptr <= ptr+1`.
- CLEAR→IDLE:
  - taken on the edge that clears `ptr == DEPTH-1`; the pointer wraps to 0;
  - `busy` falls after that edge.
- `clr_req` while in CLEAR is ignored; it does not restart or extend the sweep.
- `wr_en`=1 on an edge while in CLEAR:
  - the write is discarded; storage is untouched apart from the sweep;
  - `wr_drop` is registered high for exactly the following cycle;
  - back-to-back dropped writes hold `wr_drop` high continuously.
- Widths: address compares are `ADDR_W` bits; no arithmetic on data; pointer increment is modulo `DEPTH`.

## Timing
- Write-to-read latency is 1 cycle: data is visible on `rd_data*` after the write edge (bypass disabled).
- Clear sweep:
  - `busy` is high for exactly `DEPTH` cycles;
  - all registers read 0 once `busy` falls.
- `wr_drop` asserts the cycle after the rejected write edge.
- No combinational path from `clr_req` or `wr_en` to `busy` or `wr_drop`.

## Configuration
- `REG_FILE_BYPASS_EN` defined:
  - in IDLE, when `wr_en`=1 and `wr_addr == rd_addrN`, `rd_dataN = wr_data` combinationally in the same cycle;
  - bypass is independent per read port;
  - no bypass in CLEAR, where reads stay 0.
- `REG_FILE_BYPASS_EN` undefined: reads always return stored contents, so a same-cycle write is seen one cycle later.

## Test plan
All scenarios use `DATA_W`=8, `ADDR_W`=2.
- Reset: pulse `rst_n` low between edges → all four registers read 0x00, `busy`=0 and `wr_drop`=0 immediately, without waiting for a clock edge.
- Write/read both ports:
  - write 0xA5→R1 and 0x3C→R2;
  - set `rd_addr1`=1, `rd_addr2`=2 → 0xA5 / 0x3C;
  - set both read addresses to R1 → 0xA5 on both ports.
- Bypass:
  - `wr_en`=1, `wr_addr`=3, `wr_data`=0x7E, `rd_addr1`=3, old R3=0x00;
  - with `REG_FILE_BYPASS_EN`: 0x7E in the same cycle;
  - without it: 0x00, then 0x7E after the edge.
- Clear sweep:
  - load R0–R3 with 0x11, 0x22, 0x33, 0x44, then pulse `clr_req` one cycle;
  - `busy` is high for exactly 4 cycles and reads are 0 during the sweep;
  - after the sweep, all registers read 0x00;
  - a second `clr_req` mid-sweep does not extend `busy`.
- Dropped write: `wr_en`=1, `wr_addr`=2, `wr_data`=0xFF during `busy` → `wr_drop`=1 for one cycle; R2 reads 0x00 after the sweep.
- Reset mid-sweep: assert `rst_n` low on sweep cycle 2 → `busy`=0 immediately; the FSM returns to IDLE; a subsequent write of 0x5A→R0 reads back 0x5A.
